// File: rtl/segre_pkg.sv
// Shared constants and types for the IF-stage <-> MMU instruction-cache path.
//   ADDR_SIZE         byte address width
//   ICACHE_LANE_SIZE  lane width in bits
//   ICACHE_INDEX_SIZE line index width (NUM_LINES = 2**ICACHE_INDEX_SIZE)
//   ICACHE_BYTE_SIZE  byte-offset bits within a lane
package segre_pkg;

  localparam int unsigned ADDR_SIZE         = 32;
  localparam int unsigned ICACHE_LANE_SIZE  = 128;
  localparam int unsigned ICACHE_INDEX_SIZE = 2;
  localparam int unsigned ICACHE_BYTE_SIZE  = 4;
  localparam int unsigned ICACHE_NUM_LINES  = 1 << ICACHE_INDEX_SIZE;
  localparam int unsigned ICACHE_LANE_BYTES = 1 << ICACHE_BYTE_SIZE;
  localparam int unsigned MISS_COUNT_SIZE   = 32;

  typedef enum logic [1:0] {
    MMU_IC_IDLE,
    MMU_IC_REQ,
    MMU_IC_FILL
  } mmu_ic_fsm_e;

  // Clear the byte-offset bits so the address points at the start of its lane.
  function automatic logic [ADDR_SIZE-1:0] lane_align(input logic [ADDR_SIZE-1:0] addr);
    return addr & ~ADDR_SIZE'(ICACHE_LANE_BYTES - 1);
  endfunction

endpackage

// File: rtl/segre_mmu_icache_fill_if.sv
// IF stage <-> MMU icache handshake bundle.
//   master (IF stage): drives ic_access/ic_miss/ic_addr, receives the fill.
//   slave  (MMU)     : receives the lookup, drives mmu_data/mmu_wr_data/mmu_lru_index.
interface segre_mmu_icache_fill_if;
  import segre_pkg::*;

  logic                         ic_access;
  logic                         ic_miss;
  logic [ADDR_SIZE-1:0]         ic_addr;
  logic                         mmu_data;
  logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data;
  logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index;

  modport master (
    output ic_access, ic_miss, ic_addr,
    input  mmu_data, mmu_wr_data, mmu_lru_index
  );

  modport slave (
    input  ic_access, ic_miss, ic_addr,
    output mmu_data, mmu_wr_data, mmu_lru_index
  );

endinterface

// File: rtl/segre_icache_lru.sv
// True-LRU replacement state for the icache: one age per line, ages always a
// permutation of 0..NUM_LINES-1. The oldest line (age NUM_LINES-1) is the victim.
//   clk_i, rst_i   clock, synchronous active-high reset
//   touch_i        mark touch_idx_i as most recently used this cycle
//   touch_idx_i    line being touched
//   victim_o       current least-recently-used line (combinational)
module segre_icache_lru
  import segre_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         touch_i,
  input  logic [ICACHE_INDEX_SIZE-1:0] touch_idx_i,
  output logic [ICACHE_INDEX_SIZE-1:0] victim_o
);

  typedef logic [ICACHE_INDEX_SIZE-1:0] age_t;

  age_t age_q [ICACHE_NUM_LINES];
  age_t age_d [ICACHE_NUM_LINES];

  // Touch: lines younger than the touched one age by one, touched line becomes 0.
  always_comb begin
    age_d = age_q;
    if (touch_i) begin
      for (int unsigned i = 0; i < ICACHE_NUM_LINES; i++) begin
        if (ICACHE_INDEX_SIZE'(i) == touch_idx_i) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx_i]) begin
          age_d[i] = age_t'(age_q[i] + 1'b1);
        end
      end
    end
  end

  // Victim is the unique line holding the maximum age.
  always_comb begin
    victim_o = '0;
    for (int unsigned i = 0; i < ICACHE_NUM_LINES; i++) begin
      if (age_q[i] == age_t'(ICACHE_NUM_LINES - 1)) begin
        victim_o = ICACHE_INDEX_SIZE'(i);
      end
    end
  end

  // Reset ordering makes line 0 the oldest.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ICACHE_NUM_LINES; i++) begin
        age_q[i] <= age_t'(ICACHE_NUM_LINES - 1 - i);
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/segre_mmu_icache_fill.sv
// MMU responder for IF-stage icache misses: fetches the missing lane from memory
// and returns it as a one-cycle fill; owns the icache LRU state.
//   clk_i, rst_i     clock, synchronous active-high reset
//   ic_if            IF-stage lookup in, fill strobe/lane/victim index out
//   mem_rd_o         memory read request, held until mem_ready_i
//   mem_addr_o       lane-aligned read address
//   mem_data_i       memory read data, valid with mem_ready_i
//   mem_ready_i      single-cycle memory response
//   ic_miss_count_o  number of accepted misses (wraps)
module segre_mmu_icache_fill
  import segre_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  segre_mmu_icache_fill_if.slave      ic_if,
  output logic                        mem_rd_o,
  output logic [ADDR_SIZE-1:0]        mem_addr_o,
  input  logic [ICACHE_LANE_SIZE-1:0] mem_data_i,
  input  logic                        mem_ready_i,
  output logic [MISS_COUNT_SIZE-1:0]  ic_miss_count_o
);

  mmu_ic_fsm_e                  state_q,  state_d;
  logic [ADDR_SIZE-1:0]         addr_q,   addr_d;
  logic [ICACHE_LANE_SIZE-1:0]  lane_q,   lane_d;
  logic [ICACHE_INDEX_SIZE-1:0] victim_q, victim_d;
  logic [MISS_COUNT_SIZE-1:0]   count_q,  count_d;
  logic                         mem_rd_q, mem_rd_d;
  logic                         fill_q,   fill_d;

  logic                         touch;
  logic [ICACHE_INDEX_SIZE-1:0] touch_idx;
  logic [ICACHE_INDEX_SIZE-1:0] lru_victim;

  segre_icache_lru u_lru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .touch_i     (touch),
    .touch_idx_i (touch_idx),
    .victim_o    (lru_victim)
  );

  // Next-state, latches and LRU touch; a fill touch wins because hits are only
  // honoured in IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    victim_d  = victim_q;
    count_d   = count_q;
    touch     = 1'b0;
    touch_idx = victim_q;

    case (state_q)
      MMU_IC_IDLE: begin
        if (ic_if.ic_access) begin
          if (ic_if.ic_miss) begin
            state_d  = MMU_IC_REQ;
            addr_d   = lane_align(ic_if.ic_addr);
            victim_d = lru_victim;
            count_d  = count_q + MISS_COUNT_SIZE'(1);
          end else begin
            touch     = 1'b1;
            touch_idx = ic_if.ic_addr[ICACHE_INDEX_SIZE-1:0];
          end
        end
      end
      MMU_IC_REQ: begin
        if (mem_ready_i) begin
          lane_d  = mem_data_i;
          state_d = MMU_IC_FILL;
        end
      end
      MMU_IC_FILL: begin
        touch     = 1'b1;
        touch_idx = victim_q;
        state_d   = MMU_IC_IDLE;
      end
      default: state_d = MMU_IC_IDLE;
    endcase

    mem_rd_d = (state_d == MMU_IC_REQ);
    fill_d   = (state_d == MMU_IC_FILL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MMU_IC_IDLE;
      addr_q   <= '0;
      lane_q   <= '0;
      victim_q <= '0;
      count_q  <= '0;
      mem_rd_q <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lane_q   <= lane_d;
      victim_q <= victim_d;
      count_q  <= count_d;
      mem_rd_q <= mem_rd_d;
      fill_q   <= fill_d;
    end
  end

  assign mem_rd_o        = mem_rd_q;
  assign mem_addr_o      = addr_q;
  assign ic_miss_count_o = count_q;
  assign ic_if.mmu_data    = fill_q;
  assign ic_if.mmu_wr_data = lane_q;
  // Live LRU choice while idle; frozen at the latched victim once a miss is in flight.
  assign ic_if.mmu_lru_index = (state_q == MMU_IC_IDLE) ? lru_victim : victim_q;

endmodule

// File: tb/tb_segre_mmu_icache_fill.sv
// Self-checking bench for segre_mmu_icache_fill: directed scenarios plus a
// randomized mix of hits, misses and stray memory responses, checked against an
// MRU-ordered list model of the replacement state.
module tb_segre_mmu_icache_fill;
  import segre_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        mem_rd;
  logic [ADDR_SIZE-1:0]        mem_addr;
  logic [ICACHE_LANE_SIZE-1:0] mem_data;
  logic                        mem_ready;
  logic [31:0]                 miss_count;

  segre_mmu_icache_fill_if ic_bus ();

  segre_mmu_icache_fill dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ic_if           (ic_bus),
    .mem_rd_o        (mem_rd),
    .mem_addr_o      (mem_addr),
    .mem_data_i      (mem_data),
    .mem_ready_i     (mem_ready),
    .ic_miss_count_o (miss_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: lines ordered most-recent first; the tail is the victim.
  int unsigned lru_order[$];
  int unsigned exp_count;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    lru_order.delete();
    for (int i = 0; i < int'(ICACHE_NUM_LINES); i++) lru_order.push_front(i);
    exp_count = 0;
  endfunction

  function automatic void model_touch(input int unsigned k);
    for (int i = 0; i < lru_order.size(); i++) begin
      if (lru_order[i] == k) begin
        lru_order.delete(i);
        break;
      end
    end
    lru_order.push_front(k);
  endfunction

  function automatic int unsigned model_victim();
    return lru_order[lru_order.size() - 1];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    ic_bus.ic_access = 1'b0;
    ic_bus.ic_miss   = 1'b0;
    ic_bus.ic_addr   = '0;
    mem_ready        = 1'b0;
    mem_data         = rand128();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("rst_lru_index", 128'(ic_bus.mmu_lru_index), 128'(model_victim()));
    check_eq("rst_mem_rd", 128'(mem_rd), 128'(0));
    check_eq("rst_mmu_data", 128'(ic_bus.mmu_data), 128'(0));
    check_eq("rst_count", 128'(miss_count), 128'(0));
    check_eq("rst_mem_addr", 128'(mem_addr), 128'(0));
  endtask

  // Hit on line k while idle; called at a negedge with the DUT in IDLE.
  task automatic do_hit(input int unsigned k);
    ic_bus.ic_access = 1'b1;
    ic_bus.ic_miss   = 1'b0;
    ic_bus.ic_addr   = ADDR_SIZE'(k);
    @(negedge clk);
    ic_bus.ic_access = 1'b0;
    model_touch(k);
    check_eq("hit_lru_index", 128'(ic_bus.mmu_lru_index), 128'(model_victim()));
    check_eq("hit_no_fill", 128'(ic_bus.mmu_data), 128'(0));
  endtask

  // Full miss transaction; starts and ends at a negedge with the DUT in IDLE.
  task automatic do_miss(input logic [31:0] addr, input int dly, input logic [127:0] lane,
                         input bit hold_miss, input bit hit_in_fill);
    int unsigned v;
    v = model_victim();
    ic_bus.ic_access = 1'b1;
    ic_bus.ic_miss   = 1'b1;
    ic_bus.ic_addr   = addr;
    @(negedge clk);
    exp_count++;
    if (!hold_miss) begin
      ic_bus.ic_access = 1'b0;
      ic_bus.ic_miss   = 1'b0;
    end
    check_eq("req_mem_rd", 128'(mem_rd), 128'(1));
    check_eq("req_mem_addr", 128'(mem_addr), 128'(addr & 32'hFFFF_FFF0));
    check_eq("req_lru_index", 128'(ic_bus.mmu_lru_index), 128'(v));
    check_eq("req_count", 128'(miss_count), 128'(exp_count));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check_eq("wait_mem_rd", 128'(mem_rd), 128'(1));
      check_eq("wait_no_fill", 128'(ic_bus.mmu_data), 128'(0));
    end
    mem_ready = 1'b1;
    mem_data  = lane;
    @(negedge clk);
    mem_ready        = 1'b0;
    mem_data         = rand128();
    ic_bus.ic_access = 1'b0;
    ic_bus.ic_miss   = 1'b0;
    if (hit_in_fill) begin
      ic_bus.ic_access = 1'b1;
      ic_bus.ic_addr   = ADDR_SIZE'($urandom_range(ICACHE_NUM_LINES - 1));
    end
    check_eq("fill_strobe", 128'(ic_bus.mmu_data), 128'(1));
    check_eq("fill_wr_data", ic_bus.mmu_wr_data, lane);
    check_eq("fill_index", 128'(ic_bus.mmu_lru_index), 128'(v));
    check_eq("fill_mem_rd", 128'(mem_rd), 128'(0));
    model_touch(v);
    @(negedge clk);
    ic_bus.ic_access = 1'b0;
    check_eq("post_fill_strobe", 128'(ic_bus.mmu_data), 128'(0));
    check_eq("post_fill_wr_data", ic_bus.mmu_wr_data, lane);
    check_eq("post_fill_index", 128'(ic_bus.mmu_lru_index), 128'(model_victim()));
    check_eq("post_fill_mem_rd", 128'(mem_rd), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Reset state
    do_reset(2);

    // Single miss at 0x1234, memory answers after 3 cycles
    do_miss(32'h0000_1234, 3, 128'hDEADBEEF_0000_0000_0000_0000_0000_0001, 1'b0, 1'b0);
    check_eq("t2_victim", 128'(ic_bus.mmu_lru_index), 128'(1));
    check_eq("t2_count", 128'(miss_count), 128'(1));

    // Hits reorder LRU
    do_reset(1);
    do_hit(1); do_hit(2); do_hit(3);
    check_eq("t3_victim_a", 128'(ic_bus.mmu_lru_index), 128'(0));
    do_hit(0);
    check_eq("t3_victim_b", 128'(ic_bus.mmu_lru_index), 128'(1));

    // Long memory latency with miss held high
    do_reset(1);
    do_miss(32'h0000_4000, 20, rand128(), 1'b1, 1'b0);
    check_eq("t4_count", 128'(miss_count), 128'(1));

    // Reset during REQ abandons the request
    do_reset(1);
    ic_bus.ic_access = 1'b1;
    ic_bus.ic_miss   = 1'b1;
    ic_bus.ic_addr   = 32'h0000_0840;
    @(negedge clk);
    idle_inputs();
    check_eq("t5_req_mem_rd", 128'(mem_rd), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("t5_mem_rd", 128'(mem_rd), 128'(0));
    check_eq("t5_victim", 128'(ic_bus.mmu_lru_index), 128'(0));
    check_eq("t5_count", 128'(miss_count), 128'(0));
    mem_ready = 1'b1;
    mem_data  = rand128();
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("t5_stray_fill", 128'(ic_bus.mmu_data), 128'(0));
    @(negedge clk);
    check_eq("t5_stray_fill2", 128'(ic_bus.mmu_data), 128'(0));
    check_eq("t5_stray_mem_rd", 128'(mem_rd), 128'(0));

    // Back-to-back misses
    do_reset(1);
    do_miss(32'h0000_0100, 1, rand128(), 1'b0, 1'b0);
    do_miss(32'h0000_0200, 2, rand128(), 1'b0, 1'b1);
    check_eq("t6_count", 128'(miss_count), 128'(2));
    check_eq("t6_victim", 128'(ic_bus.mmu_lru_index), 128'(model_victim()));

    // Randomized mix against the model
    for (int it = 0; it < 200; it++) begin
      int unsigned op;
      op = $urandom_range(9);
      if (op <= 3) begin
        do_hit($urandom_range(ICACHE_NUM_LINES - 1));
      end else if (op <= 7) begin
        do_miss($urandom, int'($urandom_range(6)), rand128(),
                1'($urandom_range(1)), 1'($urandom_range(1)));
      end else if (op == 8) begin
        mem_ready = 1'b1;
        mem_data  = rand128();
        @(negedge clk);
        mem_ready = 1'b0;
        check_eq("rnd_stray_fill", 128'(ic_bus.mmu_data), 128'(0));
        check_eq("rnd_stray_mem_rd", 128'(mem_rd), 128'(0));
      end else begin
        @(negedge clk);
        check_eq("rnd_idle_index", 128'(ic_bus.mmu_lru_index), 128'(model_victim()));
      end
      check_eq("rnd_count", 128'(miss_count), 128'(exp_count));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
